// File: rtl/bc_fir_tapline.sv
// Streaming front end for the combinational FIR: ORDER+1 tap delay line fed by
// a valid/ready sample port, plus a one-entry registered result buffer.
// Optional warm-up suppression: define BC_FIR_TAPLINE_WARMUP_EN.
module bc_fir_tapline #(
  parameter int N     = 12,
  parameter int ORDER = 18,
  parameter int FW    = $clog2(ORDER + 2)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N:0]          s_data,
  output logic [ORDER:0][N:0] tap,
  input  logic [N:0]          fir_out,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [N:0]          r_data,
  output logic [FW-1:0]       fill,
  output logic                pend
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and s_ready is
  // a function of internal state and r_ready only.

  localparam logic [FW-1:0] FILL_FULL = FW'(ORDER + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(ORDER);

  logic [ORDER:0][N:0] tap_q, tap_d;
  logic                pend_q, pend_d;
  logic                r_valid_q, r_valid_d;
  logic [N:0]          r_data_q, r_data_d;
  logic [FW-1:0]       fill_q, fill_d;

  logic acc;
  logic r_free;
  logic capture;
  logic pend_set;

  always_comb begin
    r_free  = !r_valid_q || r_ready;
    capture = pend_q && r_free;
    s_ready = !pend_q || r_free;
    acc     = s_valid && s_ready;
`ifdef BC_FIR_TAPLINE_WARMUP_EN
    // Only samples that complete a real window (k >= ORDER+1) request a capture.
    pend_set = acc && (fill_q >= FILL_LAST);
`else
    pend_set = acc;
`endif
  end

  always_comb begin
    tap_d     = tap_q;
    pend_d    = pend_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    fill_d    = fill_q;
    if (clear) begin
      tap_d     = '0;
      pend_d    = 1'b0;
      r_valid_d = 1'b0;
      r_data_d  = '0;
      fill_d    = '0;
    end else begin
      if (acc) begin
        tap_d = {tap_q[ORDER-1:0], s_data};
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + 1'b1;
        end
      end
      if (pend_set) begin
        pend_d = 1'b1;
      end else if (capture) begin
        pend_d = 1'b0;
      end
      // fir_out still reflects the pre-shift taps on a capture edge.
      if (capture) begin
        r_valid_d = 1'b1;
        r_data_d  = fir_out;
      end else if (r_valid_q && r_ready) begin
        r_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tap_q     <= '0;
      pend_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      fill_q    <= '0;
    end else begin
      tap_q     <= tap_d;
      pend_q    <= pend_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      fill_q    <= fill_d;
    end
  end

  assign tap     = tap_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign fill    = fill_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_bc_fir_tapline.sv
// Directed bench for bc_fir_tapline: a reference FIR drives fir_out from the
// tap vector, and a scoreboard checks every emitted result against its window.
module tb_bc_fir_tapline;
  localparam int N     = 12;
  localparam int ORDER = 18;
  localparam int FW    = 5;
  localparam logic [N:0] B_COEF [0:ORDER] = '{
    13'd3, 13'd0, 13'd4075, 13'd0, 13'd78, 13'd0, 13'd3859, 13'd0, 13'd943,
    13'd1533, 13'd943, 13'd0, 13'd3859, 13'd0, 13'd78, 13'd0, 13'd4075, 13'd0, 13'd3};

  logic                clock;
  logic                reset;
  logic                clear;
  logic                s_valid;
  logic                s_ready;
  logic [N:0]          s_data;
  logic [ORDER:0][N:0] tap;
  logic [N:0]          fir_out;
  logic                r_valid;
  logic                r_ready;
  logic [N:0]          r_data;
  logic [FW-1:0]       fill;
  logic                pend;

  int checks   = 0;
  int failures = 0;
  int rcv_cnt  = 0;
  int n_acc    = 0;
  logic [N:0] hist[$];
  logic [N:0] exp_q[$];
  logic [N:0] exp_v;
  int unsigned fir_sum;

  bc_fir_tapline #(.N(N), .ORDER(ORDER)) dut (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tap     (tap),
    .fir_out (fir_out),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_data  (r_data),
    .fill    (fill),
    .pend    (pend)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference FIR seen by the DUT
  always_comb begin
    fir_sum = 0;
    for (int i = 0; i <= ORDER; i++) begin
      fir_sum = fir_sum + 32'(B_COEF[i]) * 32'(tap[i]);
    end
    fir_out = fir_sum[N:0];
  end

  function automatic logic [N:0] golden_at(int k);
    int unsigned s;
    s = 0;
    for (int i = 0; i <= ORDER; i++) begin
      if (k - i >= 0) s = s + 32'(B_COEF[i]) * 32'(hist[k-i]);
    end
    return s[N:0];
  endfunction

  // scoreboard: sampled at negedge, away from the active edge
  always @(negedge clock) begin
    if (reset || clear) begin
      hist.delete();
      exp_q.delete();
      n_acc = 0;
    end else begin
      if (r_valid && r_ready) begin
        rcv_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra_result: got r_data=%0d, required no result", r_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (r_data !== exp_v) begin
            failures++;
            $display("FAIL sb_r_data: got %0d, required %0d", r_data, exp_v);
          end
        end
      end
      if (s_valid && s_ready) begin
        hist.push_back(s_data);
        n_acc++;
`ifdef BC_FIR_TAPLINE_WARMUP_EN
        if (n_acc >= ORDER + 1) exp_q.push_back(golden_at(hist.size() - 1));
`else
        exp_q.push_back(golden_at(hist.size() - 1));
`endif
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
    step(); step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %0b required 1", s_ready); end
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL reset_r_valid: got %0b required 0", r_valid); end
    checks++; if (r_data !== '0) begin failures++; $display("FAIL reset_r_data: got %0d required 0", r_data); end
    checks++; if (tap !== '0) begin failures++; $display("FAIL reset_tap: got %h required 0", tap); end
    checks++; if (fill !== '0) begin failures++; $display("FAIL reset_fill: got %0d required 0", fill); end
    checks++; if (pend !== 1'b0) begin failures++; $display("FAIL reset_pend: got %0b required 0", pend); end
    reset = 1'b0;
  endtask

  task automatic test_clear();
    r_ready = 1'b1; s_valid = 1'b1; s_data = 13'd55;
    step();
    s_data = 13'd66; clear = 1'b1;
    step();
    clear = 1'b0; s_valid = 1'b0;
    checks++; if (fill !== '0) begin failures++; $display("FAIL clear_fill: got %0d required 0", fill); end
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL clear_r_valid: got %0b required 0", r_valid); end
    checks++; if (tap !== '0) begin failures++; $display("FAIL clear_tap_dropped: got %h required 0", tap); end
    checks++; if (pend !== 1'b0) begin failures++; $display("FAIL clear_pend: got %0b required 0", pend); end
    step();
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL clear_no_result: got %0b required 0", r_valid); end
  endtask

`ifndef BC_FIR_TAPLINE_WARMUP_EN
  task automatic test_impulse();
    int rcv0;
    rcv0 = rcv_cnt;
    r_ready = 1'b1; s_valid = 1'b1; s_data = 13'd1;
    step();
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL impulse_latency: r_valid got %0b required 0", r_valid); end
    for (int k = 0; k <= ORDER; k++) begin
      s_data = '0;
      s_valid = (k < ORDER);
      step();
      checks++;
      if (r_valid !== 1'b1 || r_data !== B_COEF[k]) begin
        failures++;
        $display("FAIL impulse_coef[%0d]: got valid=%0b data=%0d required valid=1 data=%0d", k, r_valid, r_data, B_COEF[k]);
      end
    end
    s_valid = 1'b0;
    step();
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL impulse_drain: r_valid got %0b required 0", r_valid); end
    checks++; if (rcv_cnt - rcv0 != ORDER + 1) begin failures++; $display("FAIL impulse_count: got %0d required %0d", rcv_cnt - rcv0, ORDER + 1); end
  endtask

  task automatic test_throughput();
    int rcv0;
    rcv0 = rcv_cnt;
    r_ready = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s_data = 13'((k * 389 + 17) % 8192);
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL thru_s_ready[%0d]: got %0b required 1", k, s_ready); end
      step();
      if (k > 0) begin
        checks++; if (r_valid !== 1'b1) begin failures++; $display("FAIL thru_b2b[%0d]: r_valid got %0b required 1", k, r_valid); end
      end
    end
    s_valid = 1'b0;
    step(); step();
    checks++; if (rcv_cnt - rcv0 != 40) begin failures++; $display("FAIL thru_count: got %0d required 40", rcv_cnt - rcv0); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL thru_leftover: got %0d required 0", exp_q.size()); end
    checks++; if (fill !== 5'd19) begin failures++; $display("FAIL thru_fill_sat: got %0d required 19", fill); end
  endtask

  task automatic test_backpressure();
    int rcv0;
    int total_acc;
    int stall_acc;
    logic [N:0] nxt;
    logic [N:0] held;
    rcv0 = rcv_cnt; total_acc = 0; stall_acc = 0;
    r_ready = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = 13'(100 + k);
      step();
      total_acc++;
    end
    s_valid = 1'b0;
    step();
    r_ready = 1'b0;
    held = r_data;
    nxt = 13'd200;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1; s_data = nxt;
      #1;
      checks++;
      if (s_ready !== (c == 0)) begin failures++; $display("FAIL bp_s_ready[%0d]: got %0b required %0b", c, s_ready, (c == 0)); end
      if (s_ready) begin stall_acc++; total_acc++; nxt = nxt + 1'b1; end
      step();
      checks++;
      if (r_valid !== 1'b1 || r_data !== held) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d required valid=1 data=%0d", c, r_valid, r_data, held);
      end
    end
    checks++; if (stall_acc != 1) begin failures++; $display("FAIL bp_extra: got %0d required 1", stall_acc); end
    r_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      s_valid = 1'b1; s_data = nxt;
      #1;
      if (s_ready) begin total_acc++; nxt = nxt + 1'b1; end
      step();
    end
    s_valid = 1'b0;
    step(); step(); step();
    checks++; if (rcv_cnt - rcv0 != total_acc) begin failures++; $display("FAIL bp_count: got %0d required %0d", rcv_cnt - rcv0, total_acc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    r_ready = 1'b1; s_valid = 1'b1; s_data = 13'd7;
    step();
    s_data = 13'd9;
    step();
    r_ready = 1'b0; s_valid = 1'b0;
    checks++; if (pend !== 1'b1 || r_valid !== 1'b1) begin failures++; $display("FAIL rmid_setup: got pend=%0b valid=%0b required 1/1", pend, r_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL rmid_r_valid: got %0b required 0", r_valid); end
    checks++; if (tap !== '0) begin failures++; $display("FAIL rmid_tap: got %h required 0", tap); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rmid_s_ready: got %0b required 1", s_ready); end
    checks++; if (fill !== '0) begin failures++; $display("FAIL rmid_fill: got %0d required 0", fill); end
    test_impulse();
  endtask
`else
  task automatic test_warmup();
    int rcv0;
    int unsigned s;
    logic [N:0] first_exp;
    s = 0;
    for (int i = 0; i <= ORDER; i++) s = s + 32'(B_COEF[i]) * 32'(19 - i);
    first_exp = s[N:0];
    rcv0 = rcv_cnt;
    r_ready = 1'b1; s_valid = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      s_data = 13'(j);
      step();
      if (j <= 19) begin
        checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL warmup_quiet[%0d]: r_valid got %0b required 0", j, r_valid); end
      end
      if (j == 20) begin
        checks++;
        if (r_valid !== 1'b1 || r_data !== first_exp) begin
          failures++;
          $display("FAIL warmup_first: got valid=%0b data=%0d required valid=1 data=%0d", r_valid, r_data, first_exp);
        end
      end
    end
    s_valid = 1'b0;
    step(); step(); step();
    checks++; if (rcv_cnt - rcv0 != 7) begin failures++; $display("FAIL warmup_count: got %0d required 7", rcv_cnt - rcv0); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL warmup_leftover: got %0d required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef BC_FIR_TAPLINE_WARMUP_EN
    test_impulse();
    test_throughput();
    test_backpressure();
    test_reset_mid();
`else
    test_warmup();
`endif
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bc_fir_tapline.md
# bc_fir_tapline

Sample-side front end for the binary-coded FIR datapath. It accepts a stream of binary samples over a valid/ready handshake and maintains the ORDER+1-deep tap delay line that drives the combinational FIR's parallel tap input. It captures the FIR result one cycle after each shift and presents it on a buffered valid/ready output. It is the producer and consumer wrapped around the FIR, converting its purely combinational tap-vector interface into a clocked streaming one.

## Interface
- N, 12: sample MSB index; samples and results are N+1 bits
- ORDER, 18: filter order; the delay line holds ORDER+1 taps
- clock  in  1  sampling clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush of taps and pipeline; same effect as reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample this cycle
- s_data  in  N+1  input sample
- tap  out  (ORDER+1)x(N+1)  delay-line vector to the FIR; tap[0] is newest
- fir_out  in  N+1  combinational FIR result computed from tap
- r_valid  out  1  result valid
- r_ready  in  1  downstream accepts the result
- r_data  out  N+1  registered FIR result

## Operation
- Accept: acc = s_valid && s_ready.
- On acc: tap[0] <= s_data; tap[i] <= tap[i-1] for i = 1..ORDER. Without acc, taps hold.
- pend: register meaning "taps changed, result not yet captured". Set on acc; cleared on capture unless a new acc occurs on the same edge.
- r_free = !r_valid || r_ready.
- Capture: when pend && r_free, r_data <= fir_out and r_valid <= 1. fir_out reflects the taps before any shift on that edge.
- r_valid clears when r_valid && r_ready && no capture occurs.
- Stall: when pend && !r_free, hold taps, hold pend, and drive s_ready = 0.
- s_ready = !pend || r_free. This is combinational and does not depend on s_valid.
- fill: counter of accepted samples, saturating at ORDER+1, 5 bits for the default configuration.
- Arithmetic: no arithmetic in this block. r_data is fir_out bit-for-bit; overflow and truncation belong to the FIR.
- Reset or clear: taps = 0, pend = 0, r_valid = 0, r_data = 0, fill = 0.
- Clear wins over a simultaneous acc or capture; the sample offered in that cycle is dropped.

## Timing
- Reset values: s_ready = 1, r_valid = 0, r_data = 0, tap = all 0.
- Latency: a sample accepted at edge E produces a result captured at edge E+1 at the earliest; r_valid is high in the cycle after E+1.
- Throughput: one sample per cycle while r_ready is held high.
- Backpressure: with r_ready low and r_valid high, at most one more sample is accepted; s_ready then drops until r_ready rises.
- Simultaneous r_ready handshake and capture: the new result replaces the old one, and r_valid stays high.
- Reset asserted mid-stream: all state returns to reset values on that edge. In-flight and pending results are discarded, not emitted.

## Configuration
- Macro: BC_FIR_TAPLINE_WARMUP_EN.
- Defined:
  - The capture for the k-th accepted sample after reset or clear is suppressed (pend not set) while k < ORDER+1.
  - The first emitted result corresponds to sample ORDER+1, with the delay line full of real samples.
  - Suppressed captures do not assert r_valid.
- Not defined: every accepted sample yields a result, with unfilled taps reading 0.

## Test plan
- Impulse, macro undefined: s_data = 1, then 18 zeros, with r_ready = 1.
  - Required: 19 consecutive results equal to coefficients b[0..18] = 3,0,4075,0,78,0,3859,0,943,1533,943,0,3859,0,78,0,4075,0,3.
  - Required: first r_valid the cycle after the second edge.
- Full throughput: s_valid = 1 for 40 cycles with r_ready = 1.
  - Required: s_ready never low.
  - Required: 40 results back to back, each matching the golden FIR of the preceding window.
- Backpressure: r_ready = 0 for 5 cycles during streaming.
  - Required: exactly one extra sample accepted, then s_ready = 0.
  - Required: r_data stable while stalled.
  - Required: no samples lost or duplicated after r_ready returns to 1.
- Warm-up with BC_FIR_TAPLINE_WARMUP_EN defined: feed samples 1..25.
  - Required: no r_valid for samples 1..18.
  - Required: the first result equals the FIR of window 19..1; 7 results total.
- Reset mid-stream: assert reset one cycle while pend = 1 and r_valid = 1.
  - Required next cycle: r_valid = 0, tap = 0, s_ready = 1.
  - Required: the next impulse reproduces the coefficient sequence.
- Clear concurrent with s_valid: sample dropped, fill = 0, no r_valid in the next cycle.
